// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with enable, used for performance debug counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, variable-latency memory handshake,
// freeze/flush handling and a saturating hazard stall counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [15:0]        stall_count
);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_target;
  logic [INSTR_W-1:0] r_buf;
  logic               r_req;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic               r_if_valid;

  logic               w_ready;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_stall_en;

  // A response only counts while our request is actually on the bus.
  assign w_ready    = imem_ready & r_req;
  assign w_pc_inc   = r_pc + ADDR_W'(PC_STEP);
  assign w_stall_en = hazard_detected & ~branch_taken;

  // Fetch FSM, PC, redirect target, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_target   <= RESET_PC;
      r_buf      <= {INSTR_W{1'b0}};
      r_req      <= 1'b0;
      r_if_pc    <= {ADDR_W{1'b0}};
      r_if_instr <= {INSTR_W{1'b0}};
      r_if_valid <= 1'b0;
    end else begin
      r_req <= 1'b1;
      case (r_state)
        ST_FETCH: begin
          if (branch_taken) begin
            r_if_valid <= 1'b0;
            r_if_instr <= INSTR_W'(NOP_INSTR);
            if (w_ready || !r_req) begin
              r_pc <= branch_addr;
            end else begin
              // Address must stay put until the outstanding response returns.
              r_target <= branch_addr;
              r_state  <= ST_DRAIN;
            end
          end else if (hazard_detected) begin
            if (w_ready) begin
              r_buf   <= imem_rdata;
              r_state <= ST_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_buf <= r_buf;
            end
          end else if (w_ready) begin
            r_if_pc    <= w_pc_inc;
            r_if_instr <= imem_rdata;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_inc;
          end else begin
            r_if_valid <= 1'b0;
            r_if_instr <= INSTR_W'(NOP_INSTR);
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            r_if_valid <= 1'b0;
            r_if_instr <= INSTR_W'(NOP_INSTR);
            r_pc       <= branch_addr;
            r_state    <= ST_FETCH;
          end else if (hazard_detected) begin
            r_req <= 1'b0;
          end else begin
            r_if_pc    <= w_pc_inc;
            r_if_instr <= r_buf;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            r_state    <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (branch_taken) begin
            r_target <= branch_addr;
          end else begin
            r_target <= r_target;
          end
          if (w_ready) begin
            r_pc    <= branch_taken ? branch_addr : r_target;
            r_state <= ST_FETCH;
          end else begin
            r_pc <= r_pc;
          end
          if (!(hazard_detected && !branch_taken)) begin
            r_if_valid <= 1'b0;
            r_if_instr <= INSTR_W'(NOP_INSTR);
          end else begin
            r_if_valid <= r_if_valid;
          end
        end
        default: begin
          r_state    <= ST_FETCH;
          r_if_valid <= 1'b0;
          r_if_instr <= INSTR_W'(NOP_INSTR);
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_stall_en),
    .o_count (stall_count)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign if_id_pc    = r_if_pc;
  assign if_id_instr = r_if_instr;
  assign if_id_valid = r_if_valid;

endmodule
